bist_misr_analyzer: RTL and testbench

- Downstream response compactor for the BIST pattern datapath.
- Consumes the 16-bit pattern word the datapath drives onto the LED bus (ring, Johnson or LFSR sequence) and folds it into a multiple-input signature register (MISR).
- After a programmed number of words, compares the signature against a golden value and reports pass/fail.
- Sits beside the control path, which drives start and data_valid; outputs feed status LEDs and the top-level wrapper.

---
 rtl/bist_misr_analyzer_if.sv | 28 ++
 rtl/bist_misr_analyzer.sv | 110 +++++++++++
 tb/tb_bist_misr_analyzer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_misr_analyzer_if.sv
// Pattern-word stream into the MISR analyzer and its status outputs.
// The master side is the control path / datapath; the slave side is the analyzer.
interface bist_misr_analyzer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err;

  modport master (
    output start, mode, data_in, data_valid, golden,
    input  signature, count, busy, done, pass, err
  );

  modport slave (
    input  start, mode, data_in, data_valid, golden,
    output signature, count, busy, done, pass, err
  );
endinterface

// File: rtl/bist_misr_analyzer.sv
// Multiple-input signature register compactor: folds a fixed number of pattern
// words into a signature, then compares it against a golden value.
module bist_misr_analyzer #(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] TAPS          = 16'hB400,
  parameter logic [WIDTH-1:0] SEED          = 16'hFFFF,
  parameter int               PATTERN_COUNT = 255,
  parameter int               CNT_W         = 8
) (
  input logic                clk,
  input logic                rst,
  bist_misr_analyzer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPACT,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PATTERN_COUNT - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] signature_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       mode_r;
  logic             pass_r;
  logic             err_r;

  logic             load;
  logic             shift;
  logic             abort;
  logic             compare;
  logic             fb;

  assign fb = ^(signature_r & TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    abort     = 1'b0;
    compare   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = S_COMPACT;
        end
      end
      S_COMPACT: begin
        // A mode change wins over a word arriving in the same cycle.
        if (bus.mode != mode_r) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end else if (bus.data_valid) begin
          shift = 1'b1;
          if (count_r == LAST_IDX) state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        compare   = 1'b1;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signature_r <= '0;
      count_r     <= '0;
      mode_r      <= '0;
      pass_r      <= 1'b0;
      err_r       <= 1'b0;
    end else if (load) begin
      signature_r <= SEED;
      count_r     <= '0;
      mode_r      <= bus.mode;
      pass_r      <= 1'b0;
      err_r       <= 1'b0;
    end else if (shift) begin
      signature_r <= {signature_r[WIDTH-2:0], fb} ^ bus.data_in;
      count_r     <= count_r + CNT_W'(1);
    end else if (abort) begin
      err_r  <= 1'b1;
      pass_r <= 1'b0;
    end else if (compare) begin
      pass_r <= (signature_r == bus.golden);
    end
  end

  assign bus.signature = signature_r;
  assign bus.count     = count_r;
  assign bus.busy      = (state == S_COMPACT) || (state == S_COMPARE);
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = pass_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Scoreboard bench for bist_misr_analyzer: three instances with PATTERN_COUNT
// 1, 2 and 4 share stimulus, gated so only the selected one sees start/valid.
module tb_bist_misr_analyzer;

  typedef struct {
    logic [1:0]  dut;
    logic [15:0] sig;
    logic [7:0]  cnt;
    logic        pass;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] data_in;
  logic        data_valid;
  logic [15:0] golden;

  logic [2:0][15:0] sig_a;
  logic [2:0][7:0]  cnt_a;
  logic [2:0]       busy_a, done_a, pass_a, err_a;
  logic [2:0]       done_q;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    bist_misr_analyzer_if #(.WIDTH(16), .CNT_W(8)) bus_if ();
    assign bus_if.start      = start && (sel == 2'(g));
    assign bus_if.mode       = mode;
    assign bus_if.data_in    = data_in;
    assign bus_if.data_valid = data_valid && (sel == 2'(g));
    assign bus_if.golden     = golden;
    bist_misr_analyzer #(.PATTERN_COUNT(PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
    );
    assign sig_a[g]  = bus_if.signature;
    assign cnt_a[g]  = bus_if.count;
    assign busy_a[g] = bus_if.busy;
    assign done_a[g] = bus_if.done;
    assign pass_a[g] = bus_if.pass;
    assign err_a[g]  = bus_if.err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s, input logic [7:0] c, input logic p, input logic e);
    exp_t x;
    x.dut = sel; x.sig = s; x.cnt = c; x.pass = p; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic start_run(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic word(input logic [15:0] d);
    data_in    = d;
    data_valid = 1'b1;
    cycle();
    data_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_a[sel] !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    check("done_wait", 32'(done_a[sel]), 32'd1);
  endtask

  // Monitor: each rising done of any instance retires the oldest expectation.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (done_a[g] === 1'b1 && done_q[g] !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(g), 32'hFFFF_FFFF);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("sb_dut",  32'(g),         32'(x.dut));
          check("sb_sig",  32'(sig_a[g]),  32'(x.sig));
          check("sb_cnt",  32'(cnt_a[g]),  32'(x.cnt));
          check("sb_pass", 32'(pass_a[g]), 32'(x.pass));
          check("sb_err",  32'(err_a[g]),  32'(x.err));
        end
      end
    end
    done_q = done_a;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sel = 2'd0; start = 1'b0; mode = 2'b00;
    data_in = '0; data_valid = 1'b0; golden = '0;
    #12;
    check("rst_sig",  32'(sig_a[0]),  32'h0);
    check("rst_cnt",  32'(cnt_a[0]),  32'h0);
    check("rst_busy", 32'(busy_a[0]), 32'h0);
    check("rst_done", 32'(done_a[0]), 32'h0);
    check("rst_pass", 32'(pass_a[0]), 32'h0);
    check("rst_err",  32'(err_a[0]),  32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Reset mid-COMPACT after 3 words, then a clean run (PATTERN_COUNT=4).
    sel = 2'd2;
    start_run(2'b00);
    word(16'h0000); word(16'h0000); word(16'h0000);
    check("pre_rst_cnt", 32'(cnt_a[2]), 32'd3);
    check("pre_rst_sig", 32'(sig_a[2]), 32'hFFF8);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_sig",  32'(sig_a[2]),  32'h0);
    check("mid_rst_cnt",  32'(cnt_a[2]),  32'h0);
    check("mid_rst_busy", 32'(busy_a[2]), 32'h0);
    check("mid_rst_done", 32'(done_a[2]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    golden = 16'hFFF0;
    push(16'hFFF0, 8'd4, 1'b1, 1'b0);
    start_run(2'b00);
    check("seed_after_rst", 32'(sig_a[2]), 32'hFFFF);
    word(16'h0000); word(16'h0000); word(16'h0000); word(16'h0000);
    wait_done();

    // PATTERN_COUNT=1: one word, done two cycles after it.
    sel = 2'd0;
    golden = 16'hFFFF;
    push(16'hFFFF, 8'd1, 1'b1, 1'b0);
    start_run(2'b00);
    word(16'h0001);
    check("lat_compare_done", 32'(done_a[0]), 32'd0);
    check("lat_compare_busy", 32'(busy_a[0]), 32'd1);
    cycle();
    check("lat_done", 32'(done_a[0]), 32'd1);

    // PATTERN_COUNT=2: zero words, matching golden, then restart from DONE.
    sel = 2'd1;
    golden = 16'hFFFC;
    push(16'hFFFC, 8'd2, 1'b1, 1'b0);
    start_run(2'b00);
    check("pc2_seed", 32'(sig_a[1]), 32'hFFFF);
    word(16'h0000);
    check("pc2_sig1", 32'(sig_a[1]), 32'hFFFE);
    check("pc2_cnt1", 32'(cnt_a[1]), 32'd1);
    word(16'h0000);
    wait_done();
    golden = 16'h1234;
    push(16'hFFFC, 8'd2, 1'b0, 1'b0);
    start_run(2'b00);
    check("restart_sig",  32'(sig_a[1]),  32'hFFFF);
    check("restart_done", 32'(done_a[1]), 32'd0);
    check("restart_busy", 32'(busy_a[1]), 32'd1);
    check("restart_cnt",  32'(cnt_a[1]),  32'd0);
    word(16'h0000); word(16'h0000);
    wait_done();

    // data_valid gaps: count and signature hold.
    golden = 16'hFFFC;
    push(16'hFFFC, 8'd2, 1'b1, 1'b0);
    start_run(2'b00);
    word(16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("gap_cnt", 32'(cnt_a[1]), 32'd1);
      check("gap_sig", 32'(sig_a[1]), 32'hFFFE);
    end
    word(16'h0000);
    wait_done();

    // start in COMPACT and COMPARE is ignored.
    push(16'hFFFC, 8'd2, 1'b1, 1'b0);
    start_run(2'b00);
    word(16'h0000);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("ign_compact_cnt", 32'(cnt_a[1]), 32'd1);
    check("ign_compact_sig", 32'(sig_a[1]), 32'hFFFE);
    word(16'h0000);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("ign_compare_done", 32'(done_a[1]), 32'd1);
    cycle();
    check("ign_compare_hold", 32'(done_a[1]), 32'd1);
    check("ign_compare_busy", 32'(busy_a[1]), 32'd0);

    // Mode change aborts; the valid word in the abort cycle is dropped.
    sel = 2'd2;
    push(16'hFFFE, 8'd1, 1'b0, 1'b1);
    start_run(2'b01);
    word(16'h0000);
    mode       = 2'b10;
    data_in    = 16'h1234;
    data_valid = 1'b1;
    cycle();
    data_valid = 1'b0;
    check("abort_done", 32'(done_a[2]), 32'd1);
    cycle();

    repeat (3) cycle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
